add8_serial: RTL and testbench

// - Multi-cycle adder, the addition counterpart of the sub8 ripple-borrow datapath: computes
//   s = a + b + ci, one DIGIT-bit slice per clock, LSB slice first, with a registered carry.
// - Trades latency for area. Serves arithmetic paths that need a sum where timing is not critical.
// - Uses a start/busy/done handshake. The result registers hold their value between operations.

---
 rtl/add8_serial.sv | 133 +++++++++++++
 tb/tb_add8_serial.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/add8_serial.sv
// add8_serial: multi-cycle adder, s = a + b + ci, one DIGIT-bit slice per clock,
// LSB slice first, with a registered carry between slices.
// Optional feature macro: ADD_SERIAL_OVF_EN adds a registered signed-overflow output `ovf`.
//
// Handshake: start is sampled only while accepting (IDLE or DONE); an accepted
// start latches a/b/ci. busy is high exactly in RUN, done exactly in DONE (a
// one-cycle pulse unless start re-launches immediately), and they are never both
// high. start while busy is ignored.
module add8_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic             co,
    output logic [WIDTH-1:0] s,
`ifdef ADD_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [WIDTH-1:0]  acc;

    logic              accept;
    logic              last_slice;
    logic [DIGIT-1:0]  sl_a;
    logic [DIGIT-1:0]  sl_b;
    logic [DIGIT-1:0]  sl_sum;
    logic              c_next;
    logic [WIDTH-1:0]  acc_next;

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_slice = (cnt == CW'(N - 1));
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign state_dbg  = state;

    // State register; reset returns to IDLE without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept from IDLE/DONE, finish RUN after the last slice.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = RUN;
            end
            RUN: begin
                if (last_slice) state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = RUN;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Current slice add: {c_next, sl_sum} = a_sl + b_sl + carry, merged into the accumulator.
    always_comb begin
        sl_a     = a_reg[cnt*DIGIT +: DIGIT];
        sl_b     = b_reg[cnt*DIGIT +: DIGIT];
        {c_next, sl_sum} = {1'b0, sl_a} + {1'b0, sl_b} + {{DIGIT{1'b0}}, carry};
        acc_next = acc;
        acc_next[cnt*DIGIT +: DIGIT] = sl_sum;
    end

    // Operand latch, slice sequencing, and result load on the edge into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            s     <= '0;
            co    <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= ci;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= c_next;
            if (last_slice) begin
                // s/co only ever change here, so partial slices are never visible.
                s   <= acc_next;
                co  <= c_next;
`ifdef ADD_SERIAL_OVF_EN
                // Carry into the MSB is recovered from the MSB sum bit and operand bits.
                ovf <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ acc_next[WIDTH-1]) ^ c_next;
`endif
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_add8_serial.sv
// tb_add8_serial: directed checks for add8_serial (WIDTH=8, DIGIT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_add8_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic       co;
    logic [7:0] s;
    logic [1:0] state_dbg;
`ifdef ADD_SERIAL_OVF_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    add8_serial #(.WIDTH(8), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .busy      (busy),
        .done      (done),
        .co        (co),
        .s         (s),
`ifdef ADD_SERIAL_OVF_EN
        .ovf       (ovf),
`endif
        .state_dbg (state_dbg)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One operation with a single-cycle start pulse; expects exactly two busy cycles,
    // s/co held at prev_s/prev_co while busy, then the result on the done cycle.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tci, input logic [7:0] prev_s, input logic prev_co,
                          input logic [7:0] es, input logic eco, input logic eovf);
        int  busy_cnt;
        bit  got;
        busy_cnt = 0;
        got      = 0;
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (done) begin
                got = 1;
            end else begin
                if (busy) begin
                    busy_cnt++;
                    check({tag, "_hold_s"}, 32'(s), 32'(prev_s));
                    check({tag, "_hold_co"}, 32'(co), 32'(prev_co));
                end
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd2);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_co"}, 32'(co), 32'(eco));
`ifdef ADD_SERIAL_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("note: no overflow expectation for %s", tag);
`endif
    endtask

    initial begin
        int  cyc;
        int  done_cyc [$];
        bit  got;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
`ifdef ADD_SERIAL_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        // 0x3C + 0x45 = 0x81: positive + positive -> negative, signed overflow.
        run_op("op_3c_45", 8'h3C, 8'h45, 1'b0, 8'h00, 1'b0, 8'h81, 1'b0, 1'b1);
        @(negedge clk);
        check("op_3c_45_done_pulse", 32'(done), 32'd0);

        // 0xFF + 0x01: carry crosses the slice boundary and out of the top.
        run_op("op_ff_01", 8'hFF, 8'h01, 1'b0, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0);

        // 0xFF + 0xFF + 1 = 0x1FF.
        run_op("op_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_done", 32'(done), 32'd0);
            check("idle_s", 32'(s), 32'hFF);
            check("idle_co", 32'(co), 32'd1);
        end

        // Start while busy must be ignored: 0x12 + 0x34 = 0x46, one done pulse.
        @(negedge clk);
        a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        check("ign_busy", 32'(busy), 32'd1);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                cyc++;
                check("ign_s", 32'(s), 32'h46);
                check("ign_co", 32'(co), 32'd0);
            end
            @(negedge clk);
        end
        check("ign_done_count", 32'(cyc), 32'd1);

        // Back-to-back with start held high: 0x10+0x20 then 0x80+0x80.
        a = 8'h10; b = 8'h20; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h80; b = 8'h80;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (done) begin
                done_cyc.push_back(i);
                if (done_cyc.size() == 1) begin
                    check("b2b_s0", 32'(s), 32'h30);
                    check("b2b_co0", 32'(co), 32'd0);
                end else begin
                    check("b2b_s1", 32'(s), 32'h00);
                    check("b2b_co1", 32'(co), 32'd1);
`ifdef ADD_SERIAL_OVF_EN
                    check("b2b_ovf1", 32'(ovf), 32'd1);
`endif
                    start = 1'b0;
                    got = 1;
                end
            end
            if (!got) @(negedge clk);
        end
        check("b2b_two_dones", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2)
            check("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
        @(negedge clk);
        check("b2b_idle", 32'(done), 32'd0);

        // Asynchronous reset mid-RUN, asserted between clock edges.
        a = 8'h55; b = 8'h22; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_co", 32'(co), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) cyc++;
        end
        check("abort_no_done", 32'(cyc), 32'd0);

        // Fresh operation after the abort.
        run_op("op_01_01", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
